lcd_ctrl: RTL and testbench

LCD_CTRL -- requirements
Module: lcd_ctrl

---
 rtl/lcd_pkg.sv | 31 +++
 rtl/lcd_delay.sv | 33 +++
 rtl/lcd_ctrl.sv | 163 ++++++++++++++++
 tb/tb_lcd_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 4-bit LCD write controller.
// Holds the FSM state encoding and the default timing constants.
package lcd_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_HOLD,
        S_GAP,
        S_EXEC
    } lcd_state_e;

    // Defaults assume a 27 MHz sys_clk.
    localparam int unsigned SETUP_CYC_DEF     = 2;
    localparam int unsigned EPW_CYC_DEF       = 13;
    localparam int unsigned HOLD_CYC_DEF      = 2;
    localparam int unsigned NIB_GAP_CYC_DEF   = 27;
    localparam int unsigned EXEC_CYC_DEF      = 1080;
    localparam int unsigned LONG_EXEC_CYC_DEF = 44280;

    // Clear-display and return-home need the long execution wait.
    function automatic logic is_long_cmd(
        input logic       rs,
        input logic       nib,
        input logic [7:0] dat
    );
        return !rs && !nib && (dat[7:2] == 6'd0);
    endfunction

endpackage

// File: rtl/lcd_delay.sv
// Loadable 16-bit down-counter; expire_o marks the last cycle
// of a loaded interval, so a load of N spans exactly N cycles.
module lcd_delay (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        load_i,
    input  logic [15:0] val_i,
    output logic        expire_o
);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = val_i;
        end else if (cnt_q != 16'd0) begin
            cnt_d = cnt_q - 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == 16'd1);

endmodule

// File: rtl/lcd_ctrl.sv
// HD44780 4-bit write controller: sends one byte or one nibble
// with E timing, then waits out the LCD execution time.
module lcd_ctrl
    import lcd_pkg::*;
#(
    parameter int unsigned SETUP_CYC     = SETUP_CYC_DEF,
    parameter int unsigned EPW_CYC       = EPW_CYC_DEF,
    parameter int unsigned HOLD_CYC      = HOLD_CYC_DEF,
    parameter int unsigned NIB_GAP_CYC   = NIB_GAP_CYC_DEF,
    parameter int unsigned EXEC_CYC      = EXEC_CYC_DEF,
    parameter int unsigned LONG_EXEC_CYC = LONG_EXEC_CYC_DEF
) (
    input  logic       sys_clk,
    input  logic       rst_n,
    input  logic       req,
    input  logic       rs,
    input  logic       nib_only,
    input  logic [7:0] data,
    output logic       busy,
    output logic       done,
    output logic       lcd_e,
    output logic       lcd_rw,
    output logic       lcd_rs,
    output logic [7:4] lcd_db
);

    localparam logic [15:0] P_SETUP = 16'(SETUP_CYC);
    localparam logic [15:0] P_EPW   = 16'(EPW_CYC);
    localparam logic [15:0] P_HOLD  = 16'(HOLD_CYC);
    localparam logic [15:0] P_GAP   = 16'(NIB_GAP_CYC);
    localparam logic [15:0] P_EXEC  = 16'(EXEC_CYC);
    localparam logic [15:0] P_LEXEC = 16'(LONG_EXEC_CYC);

    lcd_state_e  state_q, state_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        e_q, e_d;
    logic        rs_q, rs_d;
    logic [3:0]  db_q, db_d;
    logic [7:0]  dat_q, dat_d;
    logic        nib_q, nib_d;
    logic        lo_q, lo_d;
    logic        load;
    logic [15:0] load_val;
    logic        expire;

    lcd_delay u_delay (
        .clk_i   (sys_clk),
        .rst_ni  (rst_n),
        .load_i  (load),
        .val_i   (load_val),
        .expire_o(expire)
    );

    always_comb begin
        state_d  = state_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        e_d      = e_q;
        rs_d     = rs_q;
        db_d     = db_q;
        dat_d    = dat_q;
        nib_d    = nib_q;
        lo_d     = lo_q;
        load     = 1'b0;
        load_val = '0;
        unique case (state_q)
            S_IDLE: begin
                // The done cycle is still idle but must not accept a request.
                if (req && !done_q) begin
                    state_d  = S_SETUP;
                    busy_d   = 1'b1;
                    rs_d     = rs;
                    dat_d    = data;
                    nib_d    = nib_only;
                    lo_d     = 1'b0;
                    db_d     = data[7:4];
                    e_d      = 1'b0;
                    load     = 1'b1;
                    load_val = P_SETUP;
                end
            end
            S_SETUP: begin
                if (expire) begin
                    state_d  = S_PULSE;
                    e_d      = 1'b1;
                    load     = 1'b1;
                    load_val = P_EPW;
                end
            end
            S_PULSE: begin
                if (expire) begin
                    state_d  = S_HOLD;
                    e_d      = 1'b0;
                    load     = 1'b1;
                    load_val = P_HOLD;
                end
            end
            S_HOLD: begin
                if (expire) begin
                    load = 1'b1;
                    if (!lo_q && !nib_q) begin
                        state_d  = S_GAP;
                        load_val = P_GAP;
                    end else begin
                        state_d  = S_EXEC;
                        load_val = is_long_cmd(rs_q, nib_q, dat_q)
                                   ? P_LEXEC : P_EXEC;
                    end
                end
            end
            S_GAP: begin
                if (expire) begin
                    state_d  = S_SETUP;
                    lo_d     = 1'b1;
                    db_d     = dat_q[3:0];
                    load     = 1'b1;
                    load_val = P_SETUP;
                end
            end
            S_EXEC: begin
                if (expire) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            e_q     <= 1'b0;
            rs_q    <= 1'b0;
            db_q    <= '0;
            dat_q   <= '0;
            nib_q   <= 1'b0;
            lo_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            e_q     <= e_d;
            rs_q    <= rs_d;
            db_q    <= db_d;
            dat_q   <= dat_d;
            nib_q   <= nib_d;
            lo_q    <= lo_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign lcd_e  = e_q;
    assign lcd_rw = 1'b0;
    assign lcd_rs = rs_q;
    assign lcd_db = db_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Bench for lcd_ctrl: expected E pulses and busy lengths are queued
// at request time and checked when the LCD pins show them.
module tb_lcd_ctrl;

    typedef struct packed {
        logic       rs;
        logic [3:0] db;
    } nib_t;

    logic       sys_clk = 1'b0;
    logic       rst_n   = 1'b0;
    logic       req     = 1'b0;
    logic       rs      = 1'b0;
    logic       nib_only = 1'b0;
    logic [7:0] data    = 8'h00;
    logic       busy, done, lcd_e, lcd_rw, lcd_rs;
    logic [7:4] lcd_db;

    int checks = 0;
    int errors = 0;

    nib_t eq[$];
    int   bq[$];

    lcd_ctrl dut (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .req     (req),
        .rs      (rs),
        .nib_only(nib_only),
        .data    (data),
        .busy    (busy),
        .done    (done),
        .lcd_e   (lcd_e),
        .lcd_rw  (lcd_rw),
        .lcd_rs  (lcd_rs),
        .lcd_db  (lcd_db)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Pin monitor: E pulse contents/width and busy length per transfer.
    logic       prev_e = 1'b0;
    logic       prev_b = 1'b0;
    int         ecnt = 0;
    int         bcnt = 0;
    logic [3:0] rise_db = '0;
    logic       rise_rs = 1'b0;

    always @(negedge sys_clk) begin
        nib_t x;
        int   bl;
        if (!rst_n) begin
            prev_e = 1'b0;
            prev_b = 1'b0;
            ecnt   = 0;
            bcnt   = 0;
        end else begin
            if (lcd_e) begin
                ecnt++;
                if (!prev_e) begin
                    rise_db = lcd_db;
                    rise_rs = lcd_rs;
                end
            end
            if (prev_e && !lcd_e) begin
                if (eq.size() == 0) begin
                    chk("extra_e_pulse", 1, 0);
                end else begin
                    x = eq.pop_front();
                    chk("db_at_rise", 32'(rise_db), 32'(x.db));
                    chk("db_at_fall", 32'(lcd_db), 32'(x.db));
                    chk("rs_at_rise", 32'(rise_rs), 32'(x.rs));
                    chk("rs_at_fall", 32'(lcd_rs), 32'(x.rs));
                    chk("e_width", ecnt, 13);
                    chk("rw_low", 32'(lcd_rw), 0);
                end
                ecnt = 0;
            end
            if (busy) bcnt++;
            if (done || (prev_b && !busy)) begin
                chk("done_on_busy_fall", 32'(done),
                    32'(prev_b && !busy));
                if (prev_b && !busy) begin
                    if (bq.size() == 0) begin
                        chk("unexpected_busy_end", 1, 0);
                    end else begin
                        bl = bq.pop_front();
                        chk("busy_len", bcnt, bl);
                    end
                    bcnt = 0;
                end
            end
            if (done && prev_b === 1'b0 && busy === 1'b0 && ecnt > 0)
                chk("done_during_e", 1, 0);
            prev_e = lcd_e;
            prev_b = busy;
        end
    end

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    // Issue one request in a clean idle cycle, queueing what it must produce.
    task automatic send(input logic r, input logic n, input logic [7:0] d,
                        input int blen);
        int k;
        k = 0;
        while ((busy || done) && k < 50000) begin
            step();
            k++;
        end
        eq.push_back('{rs: r, db: d[7:4]});
        if (!n) eq.push_back('{rs: r, db: d[3:0]});
        bq.push_back(blen);
        req = 1'b1; rs = r; nib_only = n; data = d;
        step();
        req = 1'b0; rs = 1'b0; nib_only = 1'b0; data = 8'h00;
        chk("busy_after_req", 32'(busy), 1);
    endtask

    // Returns at the done cycle (one time unit after its edge).
    task automatic wait_done(input int budget);
        int k;
        k = 0;
        while (done !== 1'b1 && k < budget) begin
            step();
            k++;
        end
        chk("done_seen", 32'(done), 1);
    endtask

    initial begin
        #2;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_e", 32'(lcd_e), 0);
        chk("rst_rw", 32'(lcd_rw), 0);
        chk("rst_rs", 32'(lcd_rs), 0);
        chk("rst_db", 32'(lcd_db), 0);
        repeat (3) step();
        rst_n = 1'b1;
        step();

        // Data byte 'A'
        send(1'b1, 1'b0, 8'h41, 1141);
        wait_done(1200);
        step();
        chk("db_held_idle", 32'(lcd_db), 32'h1);
        chk("rs_held_idle", 32'(lcd_rs), 1);

        // Clear display: long execution wait
        send(1'b0, 1'b0, 8'h01, 44341);
        wait_done(44400);
        step();

        // Init-sequence single nibble
        send(1'b0, 1'b1, 8'h30, 1097);
        wait_done(1200);
        step();

        // Requests while busy and in the done cycle are dropped
        send(1'b1, 1'b0, 8'h7E, 1141);
        repeat (100) step();
        req = 1'b1; rs = 1'b0; data = 8'h01;
        step();
        req = 1'b0; data = 8'h00;
        wait_done(1200);
        req = 1'b1; rs = 1'b1; data = 8'hFF;
        step();
        req = 1'b0; rs = 1'b0; data = 8'h00;
        chk("done_cycle_req_ignored", 32'(busy), 0);
        repeat (60) step();
        chk("still_idle", 32'(busy), 0);
        chk("no_pending_pulses", eq.size(), 0);

        // Reset in the middle of an E pulse
        send(1'b1, 1'b0, 8'hC3, 1141);
        begin
            int k;
            k = 0;
            while (lcd_e !== 1'b1 && k < 50) begin
                step();
                k++;
            end
        end
        chk("e_high_before_rst", 32'(lcd_e), 1);
        repeat (4) step();
        rst_n = 1'b0;
        #1;
        chk("rst_mid_e", 32'(lcd_e), 0);
        chk("rst_mid_busy", 32'(busy), 0);
        chk("rst_mid_db", 32'(lcd_db), 0);
        eq.delete();
        bq.delete();
        repeat (2) step();
        rst_n = 1'b1;
        step();
        send(1'b1, 1'b0, 8'h5A, 1141);
        wait_done(1200);
        step();

        // Just above the clear/home decode: normal wait
        send(1'b0, 1'b0, 8'h04, 1141);
        wait_done(1200);
        repeat (3) step();

        chk("pulse_queue_empty", eq.size(), 0);
        chk("busy_queue_empty", bq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
